// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue/capture stage.
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam logic [DIV_WIDTH-1:0] DIV_ERR_VALUE = 16'hFFFF;
    localparam int SETTLE_MAX = 15;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Request/result handshake bundle between a producer, the issue stage and its consumer.
interface div_issue_ctrl_if;
    import div_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [DIV_WIDTH-1:0] in_dividend;
    logic [DIV_WIDTH-1:0] in_divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [DIV_WIDTH-1:0] out_quotient;
    logic [DIV_WIDTH-1:0] out_remainder;
    logic                 out_div_by_zero;
    logic                 busy;

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero, busy
    );

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero, busy
    );

endinterface

// File: rtl/divider_16bit.sv
// Combinational unsigned 16-bit divider; a multicycle path, sampled only after settling.
module divider_16bit
    import div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder
);

    // A zero divisor never gets captured, so any defined value will do here.
    always_comb begin
        quotient  = DIV_ERR_VALUE;
        remainder = DIV_ERR_VALUE;
        if (divisor != '0) begin
            quotient  = dividend / divisor;
            remainder = dividend % divisor;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/capture stage: registers operands, waits out the divider settle window,
// then captures the result and holds it under downstream backpressure.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input logic           clk,
    input logic           rst,
    div_issue_ctrl_if.slave bus
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
        $error("div_issue_ctrl: SETTLE_CYCLES must be in 1..15");
    end

    state_t               state;
    state_t               next_state;
    logic [3:0]           counter;
    logic [DIV_WIDTH-1:0] dividend_q;
    logic [DIV_WIDTH-1:0] divisor_q;
    logic [DIV_WIDTH-1:0] quotient_q;
    logic [DIV_WIDTH-1:0] remainder_q;
    logic                 div_by_zero_q;
    logic [DIV_WIDTH-1:0] div_quotient;
    logic [DIV_WIDTH-1:0] div_remainder;
    logic                 accept;

    divider_16bit u_divider (
        .dividend  (dividend_q),
        .divisor   (divisor_q),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    assign accept              = bus.in_valid && (state == IDLE);
    assign bus.in_ready        = (state == IDLE) && !rst;
    assign bus.out_valid       = (state == DONE);
    assign bus.busy            = (state != IDLE);
    assign bus.out_quotient    = quotient_q;
    assign bus.out_remainder   = remainder_q;
    assign bus.out_div_by_zero = div_by_zero_q;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (bus.in_divisor == '0) ? DONE : SETTLE;
                end
            end
            SETTLE: begin
                if (counter == 4'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Reset wins over any handshake; output registers only change on accept or capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            counter       <= 4'd0;
            dividend_q    <= '0;
            divisor_q     <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                dividend_q <= bus.in_dividend;
                divisor_q  <= bus.in_divisor;
                if (bus.in_divisor == '0) begin
                    quotient_q    <= DIV_ERR_VALUE;
                    remainder_q   <= DIV_ERR_VALUE;
                    div_by_zero_q <= 1'b1;
                end else begin
                    counter       <= 4'(SETTLE_CYCLES - 1);
                    div_by_zero_q <= 1'b0;
                end
            end else if (state == SETTLE) begin
                if (counter != 4'd0) begin
                    counter <= counter - 4'd1;
                end else begin
                    quotient_q  <= div_quotient;
                    remainder_q <= div_remainder;
                end
            end
        end
    end

endmodule
